// File: rtl/pwl_act_pkg.sv
// ============================================================================
//  Module   : pwl_act_pkg
//  Brief    : Shared encodings and constants for the piecewise-linear
//             sigmoid/tanh activation pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwl_act_pkg;

    typedef enum logic {
        MODE_SIGMOID = 1'b0,
        MODE_TANH    = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        SEG_0 = 2'd0,
        SEG_1 = 2'd1,
        SEG_2 = 2'd2,
        SEG_3 = 2'd3
    } seg_e;

    // Breakpoints and saturation limit in quarter units, so 2.25 stays exact
    // even when the input has a single fractional bit.
    localparam int c_bp1_q2 = 4;   // 1.0
    localparam int c_bp2_q2 = 9;   // 2.25
    localparam int c_bp3_q2 = 12;  // 3.0
    localparam int c_sat_q2 = 16;  // 4.0

    localparam int c_shift_seg0 = 2;
    localparam int c_shift_seg1 = 3;
    localparam int c_shift_seg2 = 4;
    localparam int c_shift_seg3 = 5;

    // Intercepts with 11 fractional bits
    localparam int c_icpt_frac = 11;
    localparam int c_icpt_seg0 = 1024;  // 0.5
    localparam int c_icpt_seg1 = 1286;  // 0.6279296875
    localparam int c_icpt_seg2 = 1570;  // 0.7666015625
    localparam int c_icpt_seg3 = 1760;  // 0.859375

    function automatic int seg_shift(input seg_e seg);
        case (seg)
            SEG_0:   return c_shift_seg0;
            SEG_1:   return c_shift_seg1;
            SEG_2:   return c_shift_seg2;
            default: return c_shift_seg3;
        endcase
    endfunction

    function automatic int seg_icpt(input seg_e seg);
        case (seg)
            SEG_0:   return c_icpt_seg0;
            SEG_1:   return c_icpt_seg1;
            SEG_2:   return c_icpt_seg2;
            default: return c_icpt_seg3;
        endcase
    endfunction

    // Enough fractional bits to hold a/32 exactly and the 11-bit intercepts
    function automatic int calc_prec(input int frac);
        return (frac + 6 > c_icpt_frac) ? frac + 6 : c_icpt_frac;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwl_seg_eval.sv
// ============================================================================
//  Module   : pwl_seg_eval
//  Brief    : Combinational segment evaluator f = a / 2^shift + intercept,
//             exact at PREC fractional bits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwl_seg_eval
    import pwl_act_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int PREC = 11
) (
    input  logic [IN_W-2:0] i_a,
    input  seg_e            i_seg,
    output logic [PREC+1:0] o_f
);

    localparam int c_frac = IN_W - 3;

    logic [PREC+1:0] w_a_p;
    logic [PREC+1:0] w_icpt;

    assign w_a_p = {i_a, {(PREC - c_frac){1'b0}}};

    always_comb begin
        w_icpt = (PREC + 2)'(seg_icpt(i_seg)) << (PREC - c_icpt_frac);
        o_f    = (w_a_p >> seg_shift(i_seg)) + w_icpt;
    end

endmodule

`default_nettype wire

// File: rtl/pwl_act_pipe.sv
// ============================================================================
//  Module   : pwl_act_pipe
//  Brief    : 3-stage piecewise-linear sigmoid/tanh unit with valid/ready on
//             both sides and a global stall.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwl_act_pipe
    import pwl_act_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [IN_W-1:0]  i_x,
    input  logic             i_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [OUT_W-1:0] o_y,
    output logic             o_sat
);

    localparam int c_frac = IN_W - 3;
    localparam int c_prec = calc_prec(c_frac);
    localparam int c_fw   = c_prec + 2;
    localparam int c_vw   = c_prec + OUT_W + 4;
    localparam int c_shl  = (OUT_W - 1 > c_prec) ? (OUT_W - 1 - c_prec) : 0;
    localparam int c_shr  = (c_prec > OUT_W - 1) ? (c_prec - (OUT_W - 1)) : 0;

    localparam logic [IN_W+2:0]        c_sat_lim = (IN_W + 3)'(c_sat_q2 << c_frac);
    localparam logic [IN_W:0]          c_bp1     = (IN_W + 1)'(c_bp1_q2 << c_frac);
    localparam logic [IN_W:0]          c_bp2     = (IN_W + 1)'(c_bp2_q2 << c_frac);
    localparam logic [IN_W:0]          c_bp3     = (IN_W + 1)'(c_bp3_q2 << c_frac);
    localparam logic signed [c_vw-1:0] c_one     = c_vw'(1) << c_prec;

    logic w_en;

    logic            w_neg;
    logic [IN_W:0]   w_ext;
    logic [IN_W:0]   w_mag;
    logic [IN_W:0]   w_a_raw;
    logic [IN_W+2:0] w_a_raw4;
    logic            w_sat;
    logic [IN_W-2:0] w_a;
    logic [IN_W:0]   w_a4;
    seg_e            w_seg;

    logic            r_s1_valid;
    logic [IN_W-2:0] r_s1_a;
    seg_e            r_s1_seg;
    logic            r_s1_neg;
    mode_e           r_s1_mode;
    logic            r_s1_sat;

    logic [c_fw-1:0] w_f;

    logic            r_s2_valid;
    logic [c_fw-1:0] r_s2_f;
    logic            r_s2_neg;
    mode_e           r_s2_mode;
    logic            r_s2_sat;

    logic signed [c_vw-1:0] w_f_s;
    logic signed [c_vw-1:0] w_t;
    logic signed [c_vw-1:0] w_v;
    logic [OUT_W-1:0]       w_y;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_y;
    logic             r_sat;

    // One stall signal for the whole pipe: bubbles are carried, never squeezed
    assign w_en        = !r_out_valid || i_out_ready;
    assign o_in_ready  = w_en;
    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;
    assign o_sat       = r_sat;

    // Operand fold: magnitude, tanh doubling, clamp just below 4.0, segment pick
    always_comb begin
        w_neg    = i_x[IN_W-1];
        w_ext    = {i_x[IN_W-1], i_x};
        w_mag    = w_neg ? -w_ext : w_ext;
        w_a_raw  = (mode_e'(i_mode) == MODE_TANH) ? {w_mag[IN_W-1:0], 1'b0} : w_mag;
        w_a_raw4 = {w_a_raw, 2'b00};
        w_sat    = (w_a_raw4 >= c_sat_lim);
        w_a      = w_sat ? '1 : w_a_raw[IN_W-2:0];
        w_a4     = {w_a, 2'b00};
        w_seg    = SEG_0;
        if (w_a4 >= c_bp3) begin
            w_seg = SEG_3;
        end else if (w_a4 >= c_bp2) begin
            w_seg = SEG_2;
        end else if (w_a4 >= c_bp1) begin
            w_seg = SEG_1;
        end
    end

    pwl_seg_eval #(
        .IN_W (IN_W),
        .PREC (c_prec)
    ) u_seg_eval (
        .i_a   (r_s1_a),
        .i_seg (r_s1_seg),
        .o_f   (w_f)
    );

    // Sign/mode fold, then floor by dropping low bits of the signed value
    always_comb begin
        w_f_s = $signed(c_vw'(r_s2_f));
        w_t   = (w_f_s <<< 1) - c_one;
        if (r_s2_mode == MODE_TANH) begin
            w_v = r_s2_neg ? -w_t : w_t;
        end else begin
            w_v = r_s2_neg ? (c_one - w_f_s) : w_f_s;
        end
        w_y = OUT_W'((w_v <<< c_shl) >>> c_shr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_seg    <= SEG_0;
            r_s1_neg    <= 1'b0;
            r_s1_mode   <= MODE_SIGMOID;
            r_s1_sat    <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_f      <= '0;
            r_s2_neg    <= 1'b0;
            r_s2_mode   <= MODE_SIGMOID;
            r_s2_sat    <= 1'b0;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= i_in_valid;
            r_s1_a      <= w_a;
            r_s1_seg    <= w_seg;
            r_s1_neg    <= w_neg;
            r_s1_mode   <= mode_e'(i_mode);
            r_s1_sat    <= w_sat;
            r_s2_valid  <= r_s1_valid;
            r_s2_f      <= w_f;
            r_s2_neg    <= r_s1_neg;
            r_s2_mode   <= r_s1_mode;
            r_s2_sat    <= r_s1_sat;
            r_out_valid <= r_s2_valid;
            r_y         <= w_y;
            r_sat       <= r_s2_sat;
        end
    end

endmodule

`default_nettype wire

// File: doc/pwl_act_pipe.md
# pwl_act_pipe

Parametrised, pipelined piecewise-linear activation unit: evaluates sigmoid or tanh per sample on a signed fixed-point input using a 4-segment shift-and-add approximation. It has valid/ready handshakes on both sides, a saturation flag and a fixed 3-stage pipeline. It sits between the accumulator output and the next layer's input buffer. It is the next generation of the fixed 8-bit registered sigmoid stage.

## Interface
- IN_W, 8, input width; two's complement, IN_W-3 fractional bits (F), range [-4, 4); legal 4..16
- OUT_W, 16, output width, OUT_W-1 fractional bits; legal 8..24
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- i_in_valid  in  1  input sample valid
- o_in_ready  out  1  unit accepts the sample this cycle
- i_x  in  IN_W  input sample
- i_mode  in  1  0 = sigmoid, 1 = tanh; sampled with i_x
- o_out_valid  out  1  o_y/o_sat valid
- i_out_ready  in  1  downstream accepts
- o_y  out  OUT_W  result: sigmoid unsigned Q1.(OUT_W-1) in [0,1); tanh two's complement Q1.(OUT_W-1)
- o_sat  out  1  operand magnitude was clamped

## Operation
- Accept when i_in_valid && o_in_ready; deliver when o_out_valid && i_out_ready.
- Magnitude: a = |x| (|x| times 2 in tanh mode). If a ≥ 4, a = 4 - 2^-F and o_sat = 1. In sigmoid mode, o_sat = 1 only for x = -4.
- Segment f(a), exact:
  - [0,1): a/4 + 0.5
  - [1,2.25): a/8 + 0.6279296875
  - [2.25,3): a/16 + 0.7666015625
  - [3,4): a/32 + 0.859375
- Segment select compares against the breakpoints 1.0, 2.25 and 3.0. Lower bounds are inclusive.
- Internal precision P = max(F+6, 11) fractional bits; no rounding before the final step.
- Sigmoid: y = f for x ≥ 0, y = 1 - f for x < 0 (true subtraction, not bit inversion).
- Tanh: t = 2f - 1; y = t for x ≥ 0, y = -t for x < 0.
- Final step: floor to OUT_W-1 fractional bits; no other rounding.

## Timing
- Three register stages:
  - S1: a, segment, sign, mode, sat
  - S2: f
  - S3: o_y, o_sat, o_out_valid
- Sample accepted at edge k loads the output register at edge k+2. Latency is 3 cycles including the accept cycle.
- Global advance: en = !o_out_valid || i_out_ready. o_in_ready = en, combinational.
- All stages advance together when en = 1. Bubbles are not squeezed; a bubble propagates as valid = 0.
- With en = 0, every stage register and o_y/o_sat hold stable. o_out_valid stays high until accepted.
- Back-to-back: one sample per cycle at full throughput when i_out_ready is held high.
- Reset: all stage valids, o_out_valid, o_y and o_sat go to 0 at the next edge. In-flight samples are discarded. o_in_ready is 1 in the first cycle after reset.
- Simultaneous accept and deliver in one cycle is legal and is the steady state.
- Mode and sign travel with the sample; mixed-mode streams need no flush.

## Structure
- pwl_act_pkg holds:
  - mode encoding (MODE_SIGMOID, MODE_TANH)
  - breakpoint constants 1.0, 2.25, 3.0 and saturation limit 4.0
  - per-segment shift amounts (2,3,4,5)
  - intercept constants at 11 fractional bits: 0.5, 0.6279296875, 0.7666015625, 0.859375
- Sub-module pwl_seg_eval is combinational: (a, segment) -> f. It is instantiated between S1 and S2.
- Handshake, fold and output registers live in the top module.

## Test plan
All vectors use IN_W=8, OUT_W=16, i_out_ready=1 unless stated.
- Sigmoid x=0x00 -> o_y=0x4000; x=0x20 (+1.0) -> 0x6060; x=0xE0 (-1.0) -> 0x1FA0; each appears 3 cycles after accept, o_sat=0.
- Breakpoints and saturation:
  - x=0x47 -> 0x73E0; x=0x48 -> 0x7420
  - x=0x7F -> 0x7DE0, o_sat=0
  - x=0x80 (-4) -> 0x0220, o_sat=1
- Tanh: x=0x10 (+0.5) -> 0x40C0; x=0xF0 (-0.5) -> 0xBF40; x=0x40 (+2.0) -> o_sat=1; alternate modes back-to-back with outputs in order.
- Backpressure:
  - Hold i_out_ready=0 while offering 5 samples; exactly 3 are accepted, then o_in_ready=0.
  - o_y stays stable until i_out_ready=1; then the remaining samples drain in order with no loss or duplication.
- Reset mid-stream: assert rst with 3 samples in flight; next cycle o_out_valid=0, o_y=0, o_in_ready=1; none of the old samples ever appear.
- Random stream with random valid/ready gaps: scoreboard against a reference model of the arithmetic above; zero mismatches over 10k samples.
